// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: control word, operands, immediates and flags.
// Define FORWARDING_EN to add the registered src1/src2 address ports.
module id_ex_stage_reg #(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 4,
  parameter int CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic [REG_W-1:0]  pc_in,
  input  logic [REG_W-1:0]  val_rn_in,
  input  logic [REG_W-1:0]  val_rm_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              s_in,
  input  logic              b_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [ADDR_W-1:0] dest_in,
  input  logic [3:0]        sr_in,
`ifdef FORWARDING_EN
  input  logic [ADDR_W-1:0] src1_in,
  input  logic [ADDR_W-1:0] src2_in,
  output logic [ADDR_W-1:0] src1_out,
  output logic [ADDR_W-1:0] src2_out,
`endif
  output logic [REG_W-1:0]  pc_out,
  output logic [REG_W-1:0]  val_rn_out,
  output logic [REG_W-1:0]  val_rm_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              s_out,
  output logic              b_out,
  output logic [CMD_W-1:0]  exe_cmd_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [ADDR_W-1:0] dest_out,
  output logic [3:0]        sr_out,
  output logic              valid_out
);

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  pc;
    logic [REG_W-1:0]  val_rn;
    logic [REG_W-1:0]  val_rm;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              s;
    logic              b;
    logic [CMD_W-1:0]  exe_cmd;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [ADDR_W-1:0] dest;
    logic [3:0]        sr;
`ifdef FORWARDING_EN
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
`endif
  } id_ex_t;

  id_ex_t d;
  id_ex_t q;
  id_ex_t nxt;

  always_comb begin
    d               = '0;
    d.valid         = 1'b1;
    d.pc            = pc_in;
    d.val_rn        = val_rn_in;
    d.val_rm        = val_rm_in;
    d.wb_en         = wb_en_in;
    d.mem_r_en      = mem_r_en_in;
    d.mem_w_en      = mem_w_en_in;
    d.s             = s_in;
    d.b             = b_in;
    d.exe_cmd       = exe_cmd_in;
    d.imm           = imm_in;
    d.shift_operand = shift_operand_in;
    d.signed_imm_24 = signed_imm_24_in;
    d.dest          = dest_in;
    d.sr            = sr_in;
`ifdef FORWARDING_EN
    d.src1          = src1_in;
    d.src2          = src2_in;
`endif
  end

  // A bubble is the all-zero word, so no side-effect bit can leak out.
  always_comb begin
    nxt = q;
    if (flush)
      nxt = '0;
    else if (!freeze)
      nxt = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else
      q <= nxt;
  end

  assign valid_out         = q.valid;
  assign pc_out            = q.pc;
  assign val_rn_out        = q.val_rn;
  assign val_rm_out        = q.val_rm;
  assign wb_en_out         = q.wb_en;
  assign mem_r_en_out      = q.mem_r_en;
  assign mem_w_en_out      = q.mem_w_en;
  assign s_out             = q.s;
  assign b_out             = q.b;
  assign exe_cmd_out       = q.exe_cmd;
  assign imm_out           = q.imm;
  assign shift_operand_out = q.shift_operand;
  assign signed_imm_24_out = q.signed_imm_24;
  assign dest_out          = q.dest;
  assign sr_out            = q.sr;
`ifdef FORWARDING_EN
  assign src1_out          = q.src1;
  assign src2_out          = q.src2;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed cases plus randomized traffic
// against a snapshot model of the stage contents.
`timescale 1ns/1ps
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in, sr_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out;
  logic        imm_out, valid_out;
  logic [3:0]  exe_cmd_out, dest_out, sr_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
`ifdef FORWARDING_EN
  logic [3:0]  src1_in, src2_in, src1_out, src2_out;
`endif

  typedef struct {
    logic [31:0] pc, rn, rm;
    logic        wb, mr, mw, s, b, imm, valid;
    logic [3:0]  cmd, dest, sr, src1, src2;
    logic [11:0] sh;
    logic [23:0] off;
  } st_t;

  st_t exp_st;
  int  total = 0;
  int  bad = 0;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .s_in(s_in), .b_in(b_in),
    .exe_cmd_in(exe_cmd_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .sr_in(sr_in),
`ifdef FORWARDING_EN
    .src1_in(src1_in), .src2_in(src2_in),
    .src1_out(src1_out), .src2_out(src2_out),
`endif
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .s_out(s_out), .b_out(b_out),
    .exe_cmd_out(exe_cmd_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .sr_out(sr_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic st_t zero_st();
    st_t z;
    z = '{default: '0};
    return z;
  endfunction

  function automatic st_t in_st();
    st_t t;
    t = '{default: '0};
    t.valid = 1'b1;
    t.pc = pc_in;   t.rn = val_rn_in;  t.rm = val_rm_in;
    t.wb = wb_en_in; t.mr = mem_r_en_in; t.mw = mem_w_en_in;
    t.s = s_in;     t.b = b_in;        t.imm = imm_in;
    t.cmd = exe_cmd_in; t.dest = dest_in; t.sr = sr_in;
    t.sh = shift_operand_in; t.off = signed_imm_24_in;
`ifdef FORWARDING_EN
    t.src1 = src1_in; t.src2 = src2_in;
`endif
    return t;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, valid_out, exp_st.valid);
    chk({tag, ".pc"}, pc_out, exp_st.pc);
    chk({tag, ".rn"}, val_rn_out, exp_st.rn);
    chk({tag, ".rm"}, val_rm_out, exp_st.rm);
    chk({tag, ".wb"}, wb_en_out, exp_st.wb);
    chk({tag, ".mr"}, mem_r_en_out, exp_st.mr);
    chk({tag, ".mw"}, mem_w_en_out, exp_st.mw);
    chk({tag, ".s"}, s_out, exp_st.s);
    chk({tag, ".b"}, b_out, exp_st.b);
    chk({tag, ".cmd"}, exe_cmd_out, exp_st.cmd);
    chk({tag, ".imm"}, imm_out, exp_st.imm);
    chk({tag, ".sh"}, shift_operand_out, exp_st.sh);
    chk({tag, ".off"}, signed_imm_24_out, exp_st.off);
    chk({tag, ".dest"}, dest_out, exp_st.dest);
    chk({tag, ".sr"}, sr_out, exp_st.sr);
`ifdef FORWARDING_EN
    chk({tag, ".src1"}, src1_out, exp_st.src1);
    chk({tag, ".src2"}, src2_out, exp_st.src2);
`endif
  endtask

  task automatic rand_in();
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom);
    mem_w_en_in = 1'($urandom); s_in = 1'($urandom);
    b_in = 1'($urandom); imm_in = 1'($urandom);
    exe_cmd_in = 4'($urandom); dest_in = 4'($urandom);
    sr_in = 4'($urandom);
    shift_operand_in = 12'($urandom);
    signed_imm_24_in = 24'($urandom);
`ifdef FORWARDING_EN
    src1_in = 4'($urandom); src2_in = 4'($urandom);
`endif
  endtask

  // Advance one rising edge and apply the stage rules to the model.
  task automatic edge_step();
    @(posedge clk);
    #1;
    if (rst)
      exp_st = zero_st();
    else if (flush)
      exp_st = zero_st();
    else if (!freeze)
      exp_st = in_st();
  endtask

  initial begin
    rand_in();
    exp_st = zero_st();
    repeat (3) edge_step();
    check_all("rst0");

    rst = 1'b0;
    rand_in();
    edge_step();
    check_all("first");

    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_st = zero_st();
    check_all("arst");
    edge_step();
    check_all("arst_hold");
    @(negedge clk);
    rst = 1'b0;
    pc_in = 32'h10;
    edge_step();
    chk("rel.pc", pc_out, 32'h10);
    chk("rel.valid", valid_out, 1'b1);

    rand_in();
    val_rn_in = 32'hDEADBEEF;
    wb_en_in = 1'b1;
    exe_cmd_in = 4'b0010;
    dest_in = 4'd5;
    #2;
    check_all("preload");
    edge_step();
    check_all("load");
    chk("load.rn_lit", val_rn_out, 32'hDEADBEEF);
    chk("load.cmd_lit", exe_cmd_out, 4'b0010);

    pc_in = 32'h20;
    edge_step();
    freeze = 1'b1;
    pc_in = 32'h24;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("frz.pc", pc_out, 32'h20);
      check_all("frz");
    end
    freeze = 1'b0;
    edge_step();
    chk("unfrz.pc", pc_out, 32'h24);

    mem_w_en_in = 1'b1; b_in = 1'b1; s_in = 1'b1; wb_en_in = 1'b1;
    flush = 1'b1;
    edge_step();
    chk("fl.mw", mem_w_en_out, 1'b0);
    chk("fl.b", b_out, 1'b0);
    chk("fl.s", s_out, 1'b0);
    chk("fl.wb", wb_en_out, 1'b0);
    chk("fl.valid", valid_out, 1'b0);
    check_all("flush");

    flush = 1'b0;
    rand_in();
    edge_step();
    chk("ld2.valid", valid_out, 1'b1);
    flush = 1'b1;
    freeze = 1'b1;
    edge_step();
    chk("flfrz.valid", valid_out, 1'b0);
    check_all("flfrz");
    flush = 1'b0;
    freeze = 1'b0;

`ifdef FORWARDING_EN
    src1_in = 4'd3;
    src2_in = 4'd7;
    edge_step();
    chk("fw.src1", src1_out, 4'd3);
    chk("fw.src2", src2_out, 4'd7);
    flush = 1'b1;
    edge_step();
    chk("fwfl.src1", src1_out, 4'd0);
    chk("fwfl.src2", src2_out, 4'd0);
    flush = 1'b0;
`endif

    for (int n = 0; n < 300; n++) begin
      rand_in();
      flush = ($urandom_range(9) == 0);
      freeze = ($urandom_range(3) == 0);
      edge_step();
      check_all("rnd");
      if (!valid_out)
        chk("rnd.bubble", {wb_en_out, mem_r_en_out, mem_w_en_out,
                           s_out, b_out}, 5'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
